// File: rtl/gpr_hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bundle: pipeline controls and the ID instruction
// fields flow in, the stall decision and MD launch/status flow out.
interface gpr_hazard_scoreboard_if;
  logic       pipe_hold;
  logic       flush;
  logic       id_valid;
  logic       id_rs_re;
  logic [4:0] id_rs;
  logic       id_rt_re;
  logic [4:0] id_rt;
  logic       id_we;
  logic [4:0] id_rd;
  logic       id_is_load;
  logic       id_is_md;
  logic       md_done;
  logic [4:0] md_done_rd;
  logic       stall;
  logic [1:0] stall_reason;
  logic       md_busy;
  logic       md_start;

  modport master (
    output pipe_hold, flush, id_valid, id_rs_re, id_rs, id_rt_re, id_rt,
           id_we, id_rd, id_is_load, id_is_md, md_done, md_done_rd,
    input  stall, stall_reason, md_busy, md_start
  );

  modport slave (
    input  pipe_hold, flush, id_valid, id_rs_re, id_rs, id_rt_re, id_rt,
           id_we, id_rd, id_is_load, id_is_md, md_done, md_done_rd,
    output stall, stall_reason, md_busy, md_start
  );
endinterface

// File: rtl/gpr_hazard_scoreboard.sv
// Tracks in-flight load and multiply/divide GPR writers the forwarding network
// cannot yet supply, stalls ID on pending operands, and launches the MD unit.
module gpr_hazard_scoreboard #(
  parameter int LOAD_USE_DIST = 1,
  parameter int NREG          = 32
) (
  input logic                    clk,
  input logic                    reset,
  gpr_hazard_scoreboard_if.slave bus
);

  localparam logic [1:0] LD_INIT = 2'(LOAD_USE_DIST);

  logic [NREG-1:0][1:0] ld_cnt_q, ld_cnt_d;
  logic [NREG-1:0]      md_pend_q, md_pend_d;
  logic                 md_busy_q, md_busy_d;

  logic [NREG-1:0] ld_wait;
  logic [NREG-1:0] md_wait;
  logic            rs_ld, rt_ld;
  logic            rs_md, rt_md, rd_md;
  logic [1:0]      reason;
  logic            issue_fire;
  logic            md_launch;
  logic            ld_launch;

  // A same-cycle MD completion is treated as available: WB forwarding covers it.
  always_comb begin
    ld_wait = '0;
    md_wait = '0;
    for (int r = 1; r < NREG; r++) begin
      ld_wait[r] = (ld_cnt_q[r] != 2'd0);
      md_wait[r] = md_pend_q[r] & ~(bus.md_done & (bus.md_done_rd == 5'(r)));
    end
  end

  always_comb begin
    rs_ld  = bus.id_rs_re & ld_wait[bus.id_rs];
    rt_ld  = bus.id_rt_re & ld_wait[bus.id_rt];
    rs_md  = bus.id_rs_re & md_wait[bus.id_rs];
    rt_md  = bus.id_rt_re & md_wait[bus.id_rt];
    rd_md  = bus.id_we    & md_wait[bus.id_rd];
    reason = 2'b00;
    if (bus.id_valid && !reset) begin
      if (bus.id_is_md && md_busy_q && !bus.md_done) begin
        reason = 2'b11;
      end else if (rs_md || rt_md || rd_md) begin
        reason = 2'b10;
      end else if (rs_ld || rt_ld) begin
        reason = 2'b01;
      end
    end
    issue_fire = bus.id_valid & (reason == 2'b00) & ~bus.pipe_hold & ~bus.flush & ~reset;
    md_launch  = issue_fire & bus.id_is_md;
    ld_launch  = issue_fire & bus.id_we & bus.id_is_load & (bus.id_rd != 5'd0);
  end

  // Load counters count pipeline advances; a new issue overrides the decrement.
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    if (bus.flush) begin
      ld_cnt_d = '0;
    end else if (!bus.pipe_hold) begin
      for (int r = 0; r < NREG; r++) begin
        if (ld_cnt_q[r] != 2'd0) begin
          ld_cnt_d[r] = ld_cnt_q[r] - 2'd1;
        end
        if (ld_launch && (bus.id_rd == 5'(r))) begin
          ld_cnt_d[r] = LD_INIT;
        end
      end
    end
  end

  // MD state survives flush: an issued MD op always completes.
  always_comb begin
    md_pend_d = md_pend_q;
    md_busy_d = md_busy_q;
    if (bus.md_done) begin
      md_pend_d[bus.md_done_rd] = 1'b0;
      md_busy_d                 = 1'b0;
    end
    if (md_launch) begin
      md_busy_d = 1'b1;
      if (bus.id_we && (bus.id_rd != 5'd0)) begin
        md_pend_d[bus.id_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_cnt_q  <= '0;
      md_pend_q <= '0;
      md_busy_q <= 1'b0;
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      md_pend_q <= md_pend_d;
      md_busy_q <= md_busy_d;
    end
  end

  assign bus.stall        = (reason != 2'b00);
  assign bus.stall_reason = reason;
  assign bus.md_busy      = md_busy_q;
  assign bus.md_start     = md_launch;

endmodule

// File: doc/gpr_hazard_scoreboard.md
Name: gpr_hazard_scoreboard

Overview:
Producer-side companion to the GPR forwarding path. It tracks in-flight GPR writers whose results the forwarding network cannot yet supply:
- fixed-latency loads, whose data is not ready until MEM;
- a variable-latency multiply/divide unit.

It sits beside the ID stage and raises a stall whenever the ID instruction's sources, destination or the MD unit are still pending. It also launches the MD unit.

Parameters:
LOAD_USE_DIST, 1, pipeline-advance cycles after issue before a load result is forwardable (legal 1..3; 2-bit counters).
NREG, 32, number of GPRs; register 0 is hardwired zero.

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
pipe_hold  input  1  global pipeline freeze (memory wait); no advance, no issue
flush  input  1  squash of younger instructions (exception/eret)
id_valid  input  1  ID holds a real instruction
id_rs_re  input  1  ID instruction reads rs
id_rs  input  5  rs address
id_rt_re  input  1  ID instruction reads rt
id_rt  input  5  rt address
id_we  input  1  ID instruction writes a GPR
id_rd  input  5  destination address
id_is_load  input  1  destination written from memory data
id_is_md  input  1  destination written by MD unit
md_done  input  1  MD unit result writes back this cycle
md_done_rd  input  5  destination of completing MD result
stall  output  1  hold IF/ID, inject bubble into EXE
stall_reason  output  2  00 none, 01 load-use, 10 MD RAW/WAW, 11 MD structural
md_busy  output  1  MD operation outstanding
md_start  output  1  one-cycle launch pulse to MD unit

Behaviour:
- State per register r:
  - ld_cnt[r] (2 bits);
  - md_pend[r] (1 bit);
  - global md_busy.
- issue_fire = id_valid & ~stall & ~pipe_hold & ~flush.
- Pending tests (rN = N ≠ 0):
  - ld_hit(a) = a ≠ 0 & ld_cnt[a] ≠ 0.
  - md_hit(a) = a ≠ 0 & md_pend[a] & ~(md_done & md_done_rd == a). A same-cycle completion counts as available; WB forwarding supplies it.
- stall is combinational and valid only when id_valid=1. Priority, first match wins:
  - 11 if id_is_md & md_busy & ~md_done;
  - 10 if md_hit on a read source, or on id_rd when id_we (WAW);
  - 01 if ld_hit on a read source;
  - otherwise 00 and stall=0.
- ld_cnt update each edge:
  - if flush, all counters → 0;
  - else if ~pipe_hold: nonzero counters decrement by 1; then if issue_fire & id_we & id_is_load & id_rd ≠ 0, ld_cnt[id_rd] ← LOAD_USE_DIST (issue overrides decrement);
  - pipe_hold freezes all counters.
- md_pend / md_busy update:
  - md_done clears md_pend[md_done_rd] and md_busy;
  - issue_fire & id_is_md sets md_busy and, if id_we & id_rd ≠ 0, md_pend[id_rd]. Set wins over a same-cycle clear.
  - flush does NOT clear MD state: an issued MD op always completes.
- md_start = issue_fire & id_is_md (combinational pulse, exactly one cycle per MD issue).
- Reset:
  - all ld_cnt = 0, all md_pend = 0, md_busy = 0;
  - stall = 0, stall_reason = 00, md_start = 0 immediately (asynchronous);
  - reset mid-MD-op abandons tracking; the MD unit shares the reset.
- id_valid=0: stall=0, reason=00, no issue.
- Writes or reads of register 0 never stall and never set state.
- md_done without md_busy: clears the named bit only; no error.

Test Plan:
1. LOAD_USE_DIST=1: issue load r5, then ID reads rs=r5 → stall=1, reason=01 for exactly 1 cycle; next cycle stall=0, ld_cnt[5]=0.
2. Load r5 issued, pipe_hold=1 for 3 cycles, then consumer of r5 → stall held through the hold; released 1 advancing cycle after hold drops.
3. MD issue rd=r8 → md_start pulse, md_busy=1. Consumer rt=r8 stalls with reason=10 for N cycles. On the md_done(rd=8) cycle stall=0 and the consumer issues.
4. Second MD op while busy → reason=11. On the md_done cycle it issues, md_start pulses, md_busy remains 1.
5. Load to r0, MD to r0, read of r0 → never stall. WAW: add writing r8 while md_pend[8] → reason=10.
6. Load r3 issued then flush → ld_cnt cleared, no stall next cycle. Asynchronous reset mid-MD → md_busy=0, stall=0 before the next edge.
